// File: rtl/sar_seq_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sar_seq_core_if
// Brief    : Result valid/ready bus of the SAR sequencer ({channel, code}).
// Revision : 1.0 - initial release
// ============================================================================
interface sar_seq_core_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (output res_data, output res_valid, input res_ready);
    modport slave  (input res_data, input res_valid, output res_ready);
endinterface
`default_nettype wire

// File: rtl/sar_seq_core.sv
`default_nettype none
// ============================================================================
// Module   : sar_seq_core
// Brief    : Multi-channel SAR conversion sequencer with result store.
//            Define SAR_RESULT_FIFO_EN for a 4-entry result FIFO instead of
//            a single result register.
// Revision : 1.0 - initial release
// ============================================================================
module sar_seq_core #(
    parameter int RES_BITS = 8,
    parameter int NUM_CH   = 4,
    parameter int SAMP_W   = 6,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_CH-1:0]   cfg_ch_mask,
    input  logic [SAMP_W-1:0]   cfg_samp_cyc,
    input  logic                cfg_cont,
    input  logic                comp_out,
    output logic                seq_init,
    output logic                seq_samp,
    output logic                seq_cmp,
    output logic                seq_logic,
    output logic [RES_BITS-1:0] dac_code,
    output logic [CH_W-1:0]     ch_sel,
    output logic                busy,
    sar_seq_core_if.master      res_if
);

    localparam int c_RES_W = CH_W + RES_BITS;
    localparam int c_BIT_W = $clog2(RES_BITS);
    localparam logic [RES_BITS-1:0] c_DAC_MSB = RES_BITS'(1) << (RES_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SAMPLE = 3'd2,
        S_CMP    = 3'd3,
        S_LOGIC  = 3'd4,
        S_PUSH   = 3'd5,
        S_WAIT   = 3'd6
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [RES_BITS-1:0] r_dac;
    logic [CH_W-1:0]     r_ch;
    logic [NUM_CH-1:0]   r_mask;
    logic                r_cont;
    logic [SAMP_W-1:0]   r_samp_cnt;
    logic [c_BIT_W-1:0]  r_bit;
    logic                r_comp;

    logic                w_start_ok;
    logic [SAMP_W-1:0]   w_samp_len;
    logic                w_samp_done;
    logic                w_full;
    logic                w_push;
    logic                w_has_next;
    logic [CH_W-1:0]     w_next_ch;
    logic                w_wrap;

    function automatic logic [CH_W-1:0] f_lowest(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (mask[j]) ch = CH_W'(j);
        end
        return ch;
    endfunction

    assign w_start_ok  = start && (cfg_ch_mask != '0);
    assign w_samp_len  = (cfg_samp_cyc == '0) ? SAMP_W'(1) : cfg_samp_cyc;
    assign w_samp_done = (r_samp_cnt == (w_samp_len - SAMP_W'(1)));
    // A scan only wraps if continuous mode is still requested at the wrap point.
    assign w_wrap      = r_cont && cfg_cont;

    always_comb begin
        w_has_next = 1'b0;
        w_next_ch  = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (r_mask[j] && (j > int'(r_ch))) begin
                w_has_next = 1'b1;
                w_next_ch  = CH_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        seq_init    = 1'b0;
        seq_samp    = 1'b0;
        seq_cmp     = 1'b0;
        seq_logic   = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_state_nxt = S_INIT;
            S_INIT: begin
                seq_init    = 1'b1;
                w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                seq_samp = 1'b1;
                if (w_samp_done) w_state_nxt = S_CMP;
            end
            S_CMP: begin
                seq_cmp     = 1'b1;
                w_state_nxt = S_LOGIC;
            end
            S_LOGIC: begin
                seq_logic   = 1'b1;
                w_state_nxt = (r_bit == '0) ? S_PUSH : S_CMP;
            end
            S_PUSH, S_WAIT: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = (w_has_next || w_wrap) ? S_SAMPLE : S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dac      <= '0;
            r_ch       <= '0;
            r_mask     <= '0;
            r_cont     <= 1'b0;
            r_samp_cnt <= '0;
            r_bit      <= '0;
            r_comp     <= 1'b0;
        end else begin
            r_comp <= comp_out;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_mask <= cfg_ch_mask;
                        r_cont <= cfg_cont;
                        r_ch   <= f_lowest(cfg_ch_mask);
                        r_dac  <= '0;
                    end
                end
                S_INIT:   r_samp_cnt <= '0;
                S_SAMPLE: begin
                    r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
                    if (w_samp_done) begin
                        r_dac <= c_DAC_MSB;
                        r_bit <= c_BIT_W'(RES_BITS - 1);
                    end
                end
                S_LOGIC: begin
                    r_dac[r_bit] <= r_comp;
                    if (r_bit != '0) begin
                        r_dac[r_bit - c_BIT_W'(1)] <= 1'b1;
                        r_bit <= r_bit - c_BIT_W'(1);
                    end
                end
                S_PUSH, S_WAIT: begin
                    if (w_push) begin
                        r_samp_cnt <= '0;
                        r_dac      <= '0;
                        if (w_has_next) begin
                            r_ch <= w_next_ch;
                        end else if (w_wrap) begin
                            r_ch   <= f_lowest(r_mask);
                            r_cont <= cfg_cont;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAR_RESULT_FIFO_EN
    localparam int c_FIFO_DEPTH = 4;

    logic [c_RES_W-1:0] r_fifo [c_FIFO_DEPTH];
    logic [1:0]         r_wptr;
    logic [1:0]         r_rptr;
    logic [2:0]         r_count;
    logic               w_pop;

    assign w_pop  = (r_count != 3'd0) && res_if.res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_full = (r_count == 3'(c_FIFO_DEPTH)) && !res_if.res_ready;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= {r_ch, r_dac};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: ;
            endcase
        end
    end

    assign res_if.res_valid = (r_count != 3'd0);
    assign res_if.res_data  = r_fifo[r_rptr];
`else
    logic [c_RES_W-1:0] r_res_data;
    logic               r_res_valid;

    assign w_full = r_res_valid && !res_if.res_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else if (w_push) begin
            r_res_data  <= {r_ch, r_dac};
            r_res_valid <= 1'b1;
        end else if (r_res_valid && res_if.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_if.res_valid = r_res_valid;
    assign res_if.res_data  = r_res_data;
`endif

    assign dac_code = r_dac;
    assign ch_sel   = r_ch;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
